// File: rtl/dsss_bpsk_mod_p.sv
// Single-clock DSSS BPSK modulator: LFSR-spread data bits drive the sign of an NCO/sine-ROM carrier.
// Optional DSSS_AMP_SCALE_EN adds an amp[7:0] port and one output scaling stage (latency 3 instead of 2).
module dsss_bpsk_mod_p #(
  parameter int                 OUT_W         = 8,
  parameter int                 PHASE_W       = 16,
  parameter int                 LUT_AW        = 6,
  parameter int                 CHIP_DIV      = 16,
  parameter int                 CHIPS_PER_BIT = 15,
  parameter int                 LFSR_W        = 4,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS     = 4'b1100,
  parameter logic [LFSR_W-1:0]  LFSR_SEED     = 4'b0001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] fcw,
  input  logic               bit_in,
  input  logic               bit_valid,
`ifdef DSSS_AMP_SCALE_EN
  input  logic [7:0]         amp,
`endif
  output logic               bit_ready,
  output logic [OUT_W-1:0]   mod_out,
  output logic               mod_valid,
  output logic               busy
);

  localparam int N   = 1 << LUT_AW;
  localparam int AMP = (1 << (OUT_W - 1)) - 1;
  localparam int SW  = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
  localparam int CW  = (CHIPS_PER_BIT > 1) ? $clog2(CHIPS_PER_BIT) : 1;

  // Only the first quarter wave is evaluated; the rest is mirrored so the table is exactly odd-symmetric.
  function automatic int rom_val(input int k);
    int  j;
    int  r;
    bit  neg;
    real x;
    real t;
    real s;
    j   = k;
    neg = 1'b0;
    if (j >= N / 2) begin
      j   = j - N / 2;
      neg = 1'b1;
    end
    if (j > N / 4) j = N / 2 - j;
    x = 6.283185307179586 * $itor(j) / $itor(N);
    s = x;
    t = x;
    for (int i = 1; i < 10; i++) begin
      t = -t * x * x / $itor((2 * i) * (2 * i + 1));
      s = s + t;
    end
    s = s * $itor(AMP);
    r = $rtoi(s + 0.5);
    return neg ? -r : r;
  endfunction

  logic signed [OUT_W-1:0] rom [N];
  for (genvar k = 0; k < N; k++) begin : g_rom
    assign rom[k] = OUT_W'(rom_val(k));
  end

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic                    bit_q;
  logic [PHASE_W-1:0]      phase;
  logic [SW-1:0]           samp_cnt;
  logic [CW-1:0]           chip_cnt;
  logic [LFSR_W-1:0]       lfsr;
  logic                    accept;
  logic                    last_samp;
  logic                    last_chip;
  logic                    chip;
  logic [LUT_AW-1:0]       idx;
  logic signed [OUT_W-1:0] rom_s;
  logic signed [OUT_W-1:0] samp;
  logic signed [OUT_W-1:0] s1;
  logic                    s1_vld;
  logic                    fb;

  assign last_samp = (samp_cnt == SW'(CHIP_DIV - 1));
  assign last_chip = (chip_cnt == CW'(CHIPS_PER_BIT - 1));
  assign fb        = ^(lfsr & LFSR_TAPS);
  assign chip      = bit_q ^ lfsr[LFSR_W-1];
  assign idx       = phase[PHASE_W-1 -: LUT_AW];
  assign rom_s     = rom[idx];
  assign samp      = chip ? rom_s : -rom_s;
  assign busy      = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bit_ready = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        bit_ready = 1'b1;
        if (bit_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_samp && last_chip) begin
          bit_ready = 1'b1;
          if (bit_valid) accept    = 1'b1;
          else           state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q    <= 1'b0;
      phase    <= '0;
      samp_cnt <= '0;
      chip_cnt <= '0;
      lfsr     <= LFSR_SEED;
      s1       <= '0;
      s1_vld   <= 1'b0;
    end else begin
      s1_vld <= (state == RUN);
      s1     <= (state == RUN) ? samp : '0;
      if (state == IDLE) begin
        if (accept) begin
          bit_q    <= bit_in;
          phase    <= '0;
          samp_cnt <= '0;
          chip_cnt <= '0;
        end
      end else begin
        // Phase keeps running across bit boundaries so back-to-back bits stay phase-continuous.
        phase <= phase + fcw;
        if (last_samp) begin
          samp_cnt <= '0;
          lfsr     <= {lfsr[LFSR_W-2:0], fb};
          chip_cnt <= last_chip ? '0 : chip_cnt + CW'(1);
        end else begin
          samp_cnt <= samp_cnt + SW'(1);
        end
        if (accept) bit_q <= bit_in;
      end
    end
  end

`ifdef DSSS_AMP_SCALE_EN
  logic signed [OUT_W+8:0] prod;
  logic signed [OUT_W-1:0] s2;
  logic                    s2_vld;

  assign prod = s1 * $signed({1'b0, amp});

  always_ff @(posedge clk) begin
    if (rst) begin
      s2        <= '0;
      s2_vld    <= 1'b0;
      mod_out   <= '0;
      mod_valid <= 1'b0;
    end else begin
      s2        <= OUT_W'(prod >>> 8);
      s2_vld    <= s1_vld;
      mod_out   <= s2;
      mod_valid <= s2_vld;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      mod_out   <= '0;
      mod_valid <= 1'b0;
    end else begin
      mod_out   <= s1;
      mod_valid <= s1_vld;
    end
  end
`endif

endmodule

// File: tb/tb_dsss_bpsk_mod_p.sv
// Randomised bench for dsss_bpsk_mod_p against a per-sample behavioural model (default parameters).
module tb_dsss_bpsk_mod_p;

`ifdef DSSS_AMP_SCALE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int D   = LAT - 1;
  localparam int SPB = 240;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fcw;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic [7:0]  mod_out;
  logic        mod_valid;
  logic        busy;
`ifdef DSSS_AMP_SCALE_EN
  logic [7:0]  amp;
`endif

  dsss_bpsk_mod_p dut (
    .clk       (clk),
    .rst       (rst),
    .fcw       (fcw),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
`ifdef DSSS_AMP_SCALE_EN
    .amp       (amp),
`endif
    .bit_ready (bit_ready),
    .mod_out   (mod_out),
    .mod_valid (mod_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int rom_m [64];
  int pn_seq [15];
  int pn_period;

  int running = 0, cur_bit = 0, k = 0, g = 0, phase = 0, acc = 0, cyc = 0;
  int pipe_v [D];
  int pipe_d [D];
  int exp_vld = 0, exp_dat = 0;

  function automatic int fdiv256(input int v);
    return (v >= 0) ? v / 256 : -((-v + 255) / 256);
  endfunction

  task automatic model_init();
    real r;
    logic [3:0] st;
    logic fbit;
    for (int i = 0; i < 64; i++) begin
      r = 127.0 * $sin(2.0 * 3.14159265358979 * i / 64.0);
      rom_m[i] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    end
    st = 4'b0001;
    pn_period = 0;
    for (int i = 0; i < 100; i++) begin
      if (i < 15) pn_seq[i] = int'(st[3]);
      fbit = st[3] ^ st[2];
      st = {st[2:0], fbit};
      if (pn_period == 0 && st == 4'b0001) pn_period = i + 1;
    end
    for (int i = 0; i < D; i++) begin
      pipe_v[i] = 0;
      pipe_d[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    int s, nv, nd;
    cyc++;
    exp_vld = pipe_v[D-1];
    exp_dat = pipe_d[D-1];
    for (int i = D - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_d[i] = pipe_d[i-1];
    end
    nv = 0;
    nd = 0;
    if (rst) begin
      running = 0; k = 0; g = 0; phase = 0;
      for (int i = 0; i < D; i++) begin
        pipe_v[i] = 0;
        pipe_d[i] = 0;
      end
      exp_vld = 0;
      exp_dat = 0;
    end else begin
      if (running != 0) begin
        s = ((cur_bit ^ pn_seq[g % 15]) != 0) ? rom_m[phase >> 10] : -rom_m[phase >> 10];
`ifdef DSSS_AMP_SCALE_EN
        s = fdiv256(s * int'(amp));
`endif
        nv = 1;
        nd = s;
        phase = (phase + int'(fcw)) % 65536;
        k++;
        if (k % 16 == 0) g++;
        if (k == SPB) begin
          if (bit_valid) begin
            cur_bit = int'(bit_in); k = 0; acc++;
          end else begin
            running = 0;
          end
        end
      end else if (bit_valid) begin
        running = 1; cur_bit = int'(bit_in); k = 0; phase = 0; acc++;
      end
      pipe_v[0] = nv;
      pipe_d[0] = nd;
    end
  end

  // ---------------- per-cycle compare + measurements ----------------
  int vld_cnt, run_len, max_run, rdy_cnt, first_cyc, smax, smin;
  int first_s [8];

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("mod_valid", int'(mod_valid), exp_vld);
      check("mod_out", int'($signed(mod_out)), exp_dat);
      check("bit_ready", int'(bit_ready), (running == 0 || k == SPB - 1) ? 1 : 0);
      check("busy", int'(busy), running);
    end
    if (mod_valid) begin
      if (vld_cnt < 8) first_s[vld_cnt] = int'($signed(mod_out));
      vld_cnt++;
      run_len++;
      if (first_cyc < 0) first_cyc = cyc;
      if (int'($signed(mod_out)) > smax) smax = int'($signed(mod_out));
      if (int'($signed(mod_out)) < smin) smin = int'($signed(mod_out));
    end else begin
      run_len = 0;
    end
    if (run_len > max_run) max_run = run_len;
    if (bit_ready && busy) rdy_cnt++;
  end

  task automatic clear_meas();
    vld_cnt = 0; run_len = 0; max_run = 0; rdy_cnt = 0; first_cyc = -1; smax = -1000; smin = 1000;
  endtask

  task automatic wait_acc(input int target, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (acc >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_accept_timeout"}, acc, target);
  endtask

  int hs_cyc;
  task automatic send_bit(input logic b);
    bit_in = b;
    bit_valid = 1'b1;
    wait_acc(acc + 1, "send_bit");
    hs_cyc = cyc;
    bit_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk); #1;
      if (running == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", running, 0);
    repeat (LAT + 2) @(posedge clk);
    #1;
  endtask

  int pv;

  initial begin
    model_init();
    rst = 1'b1; fcw = 16'h1000; bit_in = 1'b0; bit_valid = 1'b0;
`ifdef DSSS_AMP_SCALE_EN
    amp = 8'h80;
`endif
    clear_meas();

    // Model pins
    check("rom_m0", rom_m[0], 0);
    check("rom_m4", rom_m[4], 49);
    check("rom_m8", rom_m[8], 90);
    check("rom_m12", rom_m[12], 117);
    check("rom_m16", rom_m[16], 127);
    check("rom_m48", rom_m[48], -127);
    pv = 0;
    for (int i = 0; i < 15; i++) pv |= pn_seq[i] << i;
    check("pn_seq_bits", pv, 31432);
    check("pn_period", pn_period, 15);

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mod_out", int'(mod_out), 0);
    check("rst_mod_valid", int'(mod_valid), 0);
    check("rst_bit_ready", int'(bit_ready), 1);
    check("rst_busy", int'(busy), 0);

    // Single bit 1
    @(posedge clk); #1;
    clear_meas();
    send_bit(1'b1);
    wait_idle();
    check("t1_latency", first_cyc - hs_cyc, LAT);
    check("t1_count", vld_cnt, SPB);
`ifndef DSSS_AMP_SCALE_EN
    check("t1_s0", first_s[0], 0);
    check("t1_s1", first_s[1], 49);
    check("t1_s2", first_s[2], 90);
    check("t1_s3", first_s[3], 117);
    check("t1_s4", first_s[4], 127);
`endif

    // Single bit 0
    clear_meas();
    send_bit(1'b0);
    wait_idle();
    check("t2_count", vld_cnt, SPB);
    check("t2_end_valid", int'(mod_valid), 0);
`ifndef DSSS_AMP_SCALE_EN
    check("t2_s4", first_s[4], -127);
`endif

    // Four bits streamed with bit_valid held high
    clear_meas();
    begin
      int a0;
      a0 = acc;
      bit_in = 1'($urandom);
      bit_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        wait_acc(a0 + i + 1, "stream");
        if (i < 3) bit_in = 1'($urandom);
        else       bit_valid = 1'b0;
      end
    end
    wait_idle();
    check("t3_count", vld_cnt, 4 * SPB);
    check("t3_contiguous", max_run, 4 * SPB);
    check("t3_ready_pulses", rdy_cnt, 4);
`ifdef DSSS_AMP_SCALE_EN
    check("t3_peak_pos", smax, 63);
    check("t3_peak_neg", smin, -64);
`else
    check("t3_peak_pos", smax, 127);
    check("t3_peak_neg", smin, -127);
`endif

    // Random bits, random fcw, random gaps, mid-bit fcw changes
    for (int n = 0; n < 8; n++) begin
      fcw = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_bit(1'($urandom));
      repeat ($urandom_range(20, 230)) @(posedge clk);
      #1 fcw = 16'($urandom);
    end
    wait_idle();

    // Reset at sample 100 of a bit, then clean restart
    fcw = 16'h1000;
    clear_meas();
    send_bit(1'b1);
    for (int i = 0; i < 400 && vld_cnt < 100; i++) @(posedge clk);
    check("t5_reached_100", (vld_cnt >= 100) ? 1 : 0, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5_rst_mod_out", int'(mod_out), 0);
    check("t5_rst_mod_valid", int'(mod_valid), 0);
    check("t5_rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    clear_meas();
    send_bit(1'b0);
    wait_idle();
    check("t5_latency", first_cyc - hs_cyc, LAT);
    check("t5_count", vld_cnt, SPB);
`ifndef DSSS_AMP_SCALE_EN
    check("t5_s4", first_s[4], -127);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
